// File: rtl/pingpong_sched.sv
// Clocked ping/pong turn scheduler: hands one token alternately to agent A and B
// with a programmable start-up delay, inter-turn gap and round limit.
module pingpong_sched #(
    parameter int START_DELAY = 100,
    parameter int DELAY       = 1,
    parameter int ROUNDS      = 10,
    parameter int CW          = $clog2(ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          a_done,
    input  logic          b_done,
    output logic          a_go,
    output logic          b_go,
    output logic [CW-1:0] round_cnt,
    output logic          busy,
    output logic          finished
);

    localparam int MAXD = (START_DELAY > DELAY) ? START_DELAY : DELAY;
    localparam int CNTW = (MAXD < 1) ? 1 : $clog2(MAXD + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_PING  = 3'd2;
    localparam logic [2:0] S_GAP_A = 3'd3;
    localparam logic [2:0] S_PONG  = 3'd4;
    localparam logic [2:0] S_GAP_B = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]      r_state;
    logic [CNTW-1:0] r_cnt;
    logic [CW-1:0]   r_round;
    logic [CW-1:0]   w_round_nxt;
    logic            w_cnt_last;

    assign w_round_nxt = r_round + 1'b1;
    assign w_cnt_last  = (r_cnt == CNTW'(1));

    // abort outranks every other input, including a coincident start or b_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_round <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_round <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_round <= '0;
                        if (START_DELAY == 0) begin
                            r_state <= S_PING;
                        end else begin
                            r_cnt   <= CNTW'(START_DELAY);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_cnt_last) r_state <= S_PING;
                    else            r_cnt   <= r_cnt - 1'b1;
                end
                S_PING: begin
                    if (a_done) begin
                        if (DELAY == 0) begin
                            r_state <= S_PONG;
                        end else begin
                            r_cnt   <= CNTW'(DELAY);
                            r_state <= S_GAP_A;
                        end
                    end
                end
                S_GAP_A: begin
                    if (w_cnt_last) r_state <= S_PONG;
                    else            r_cnt   <= r_cnt - 1'b1;
                end
                S_PONG: begin
                    if (b_done) begin
                        r_round <= w_round_nxt;
                        if (w_round_nxt == CW'(ROUNDS)) begin
                            r_state <= S_DONE;
                        end else if (DELAY == 0) begin
                            r_state <= S_PING;
                        end else begin
                            r_cnt   <= CNTW'(DELAY);
                            r_state <= S_GAP_B;
                        end
                    end
                end
                S_GAP_B: begin
                    if (w_cnt_last) r_state <= S_PING;
                    else            r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once
    assign a_go      = (r_state == S_PING);
    assign b_go      = (r_state == S_PONG);
    assign finished  = (r_state == S_DONE);
    assign busy      = (r_state == S_WAIT)  || (r_state == S_PING) ||
                       (r_state == S_GAP_A) || (r_state == S_PONG) ||
                       (r_state == S_GAP_B);
    assign round_cnt = r_round;

endmodule

// File: doc/pingpong_sched.md
# pingpong_sched

Synthesizable scheduler that alternates a single shared turn token between two agents, "ping" (A) and "pong" (B), with programmable start-up delay, inter-turn gap and round limit. It replaces the event-driven ping/pong sequencing used in scheduler tests with a clocked controller. It sits between a test harness (start/abort/finished) and two handshaking agents (go/done).

## Interface
Parameters:
- START_DELAY, 100, cycles from accepted start to first a_go (0 allowed)
- DELAY, 1, gap cycles between one agent's done and the other agent's go (0 allowed)
- ROUNDS, 10, completed pong turns before finishing (>=1)
- CW, $clog2(ROUNDS+1), round counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- abort  in  1  terminate run, return to IDLE; highest priority
- a_done  in  1  ping agent finished its turn; sampled only in PING
- b_done  in  1  pong agent finished its turn; sampled only in PONG
- a_go  out  1  ping agent owns token (level)
- b_go  out  1  pong agent owns token (level)
- round_cnt  out  CW  completed pong turns in current run
- busy  out  1  state not IDLE and not DONE
- finished  out  1  ROUNDS reached (sticky until start/abort)

## Operation
- States: IDLE, WAIT, PING, GAP_A, PONG, GAP_B, DONE. One down-counter cnt (width to hold max(START_DELAY, DELAY)).
- Outputs are decoded from registered state: a_go=(PING), b_go=(PONG), busy=(WAIT|PING|GAP_A|PONG|GAP_B), finished=(DONE). a_go and b_go never both 1.
- Reset: state=IDLE, cnt=0, round_cnt=0; thus a_go=b_go=busy=finished=0.
- IDLE/DONE, start=1: round_cnt<=0; if START_DELAY==0 -> PING, else cnt<=START_DELAY, -> WAIT.
- WAIT: if cnt==1 -> PING, else cnt<=cnt-1.
- PING, a_done=1: if DELAY==0 -> PONG, else cnt<=DELAY, -> GAP_A. a_done=0: hold.
- GAP_A: if cnt==1 -> PONG, else decrement.
- PONG, b_done=1: round_cnt<=round_cnt+1; if round_cnt+1==ROUNDS -> DONE; else if DELAY==0 -> PING; else cnt<=DELAY, -> GAP_B.
- GAP_B: if cnt==1 -> PING, else decrement.
- abort=1 in any state: -> IDLE, round_cnt<=0, no round counted even if b_done also 1. abort beats start.
- start outside IDLE/DONE ignored. a_done outside PING and b_done outside PONG ignored (no error, no latching).
- round_cnt never exceeds ROUNDS; no wrap.

## Timing
- Edge E0 samples start=1 in IDLE: a_go is 1 after edge E0+START_DELAY.
- Agent done accepted on the edge where it is sampled with the corresponding go=1; a done asserted combinationally in the first go cycle is accepted (minimum turn = 1 cycle).
- a_done sampled at edge Ea: a_go 0 after Ea; b_go 1 after Ea+DELAY (after Ea when DELAY=0, go switches A->B in one edge with no gap cycle).
- b_done at Eb: round_cnt updates after Eb; finished 1 after Eb on final round; otherwise a_go 1 after Eb+DELAY.
- Full run with one-cycle agents: finished rises START_DELAY + ROUNDS*(2+2*DELAY) - DELAY cycles after E0.
- Async reset mid-run: outputs drop immediately on rst_n fall, no clock needed; restart requires new start after rst_n release.

## Test plan
- Defaults, agents respond with done 1 cycle after go: a_go first high 100 cycles after start; 10 ping/pong alternations; round_cnt 1..10; finished rises at cycle 100+10*4-1=139 after E0; a_go/b_go never overlap.
- START_DELAY=0, DELAY=0, ROUNDS=3, done tied high: a_go after E0, then b_go, alternating every edge; finished after 6 edges; busy low in DONE.
- Agent stalls 20 cycles in PING: a_go held 20+ cycles, b_go 0, cnt frozen; spurious b_done pulses during PING ignored, round_cnt unchanged.
- abort coincident with b_done on round 5: IDLE next edge, round_cnt=0, finished=0; later start replays full 100-cycle delay.
- rst_n asserted during GAP_A: all outputs 0 asynchronously; start during busy ignored, start in DONE restarts with round_cnt cleared and finished deasserted after E0.
